// File: rtl/reg_file.sv
// MiniRISC architectural register file: R0..R(NREG-2) in flops, top index aliases the
// externally supplied PC+8, with optional same-cycle write-through to both read ports.
module reg_file #(
  parameter int N      = 32,
  parameter int NREG   = 16,
  parameter int BYPASS = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    RegWrite,
  input  logic [$clog2(NREG)-1:0] A1,
  input  logic [$clog2(NREG)-1:0] A2,
  input  logic [$clog2(NREG)-1:0] A3,
  input  logic [N-1:0]            WD3,
  input  logic [N-1:0]            R15,
  output logic [N-1:0]            RD1,
  output logic [N-1:0]            RD2
);
  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] PC_IDX = AW'(NREG - 1);

  logic [N-1:0] regs [NREG-1];
  logic         wr_ok;
  logic         fwd;

  // Writes aimed at the PC alias are dropped; the fetch stage owns the PC.
  assign wr_ok = RegWrite && (A3 != PC_IDX);
  // Forwarding is gated by reset so WD3 never leaks through while rst_n is low.
  assign fwd   = (BYPASS != 0) && rst_n && wr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG - 1; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[A3] <= WD3;
    end
  end

  always_comb begin
    RD1 = '0;
    if (A1 == PC_IDX)           RD1 = R15;
    else if (fwd && (A3 == A1)) RD1 = WD3;
    else                        RD1 = regs[A1];
  end

  always_comb begin
    RD2 = '0;
    if (A2 == PC_IDX)           RD2 = R15;
    else if (fwd && (A3 == A2)) RD2 = WD3;
    else                        RD2 = regs[A2];
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed checks of reg_file with and without forwarding, plus a short random sweep
// against a reference array.
module tb_reg_file;
  logic        clk;
  logic        rst_n;
  logic        RegWrite;
  logic [3:0]  A1, A2, A3;
  logic [31:0] WD3, R15;
  logic [31:0] RD1, RD2;    // BYPASS=1
  logic [31:0] RD1n, RD2n;  // BYPASS=0

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] mdl [15];

  reg_file #(.N(32), .NREG(16), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .A1(A1), .A2(A2), .A3(A3),
    .WD3(WD3), .R15(R15), .RD1(RD1), .RD2(RD2)
  );

  reg_file #(.N(32), .NREG(16), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .A1(A1), .A2(A2), .A3(A3),
    .WD3(WD3), .R15(R15), .RD1(RD1n), .RD2(RD2n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference read: PC alias, then forwarding, then stored value.
  function automatic logic [31:0] ref_rd(input logic [3:0] a, input bit byp);
    if (a == 4'd15) return R15;
    if (byp && rst_n && RegWrite && A3 != 4'd15 && A3 == a) return WD3;
    return mdl[a];
  endfunction

  // Advance one edge; the model commits what the DUT should commit.
  task automatic tick();
    if (rst_n && RegWrite && A3 != 4'd15) mdl[A3] = WD3;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    RegWrite = 1'b1; A3 = a; WD3 = d;
    tick();
    RegWrite = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 15; i++) mdl[i] = '0;
    rst_n = 1'b0; RegWrite = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD3 = '0; R15 = 32'h108;
    #2;
    // Reset state
    A1 = 4'd0; A2 = 4'd14; #1;
    chk("rst_rd1_r0", RD1, 32'h0);
    chk("rst_rd2_r14", RD2, 32'h0);
    A1 = 4'd15; #1;
    chk("rst_rd1_pc", RD1, 32'h108);
    RegWrite = 1'b1; A3 = 4'd5; WD3 = 32'hCAFEF00D; A2 = 4'd5; #1;
    chk("rst_no_bypass", RD2, 32'h0);
    @(posedge clk); #1;
    chk("rst_no_write", RD2, 32'h0);
    RegWrite = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Write / readback
    wr(4'd3, 32'hDEADBEEF);
    wr(4'd7, 32'h00000001);
    A1 = 4'd3; A2 = 4'd7; #1;
    chk("wr_rd1_r3", RD1, 32'hDEADBEEF);
    chk("wr_rd2_r7", RD2, 32'h00000001);
    chk("wr_nb_rd1_r3", RD1n, 32'hDEADBEEF);

    // Forwarding vs. none, same-cycle triple collision
    RegWrite = 1'b1; A3 = 4'd5; A1 = 4'd5; A2 = 4'd5; WD3 = 32'h12345678; #1;
    chk("byp_rd1", RD1, 32'h12345678);
    chk("byp_rd2", RD2, 32'h12345678);
    chk("nobyp_rd1", RD1n, 32'h0);
    chk("nobyp_rd2", RD2n, 32'h0);
    tick();
    RegWrite = 1'b0; #1;
    chk("post_byp_rd1", RD1, 32'h12345678);
    chk("post_nobyp_rd2", RD2n, 32'h12345678);

    // Back-to-back writes, last wins
    wr(4'd9, 32'h11111111);
    wr(4'd9, 32'h22222222);
    A1 = 4'd9; #1;
    chk("b2b_last_wins", RD1, 32'h22222222);

    // PC alias write is dropped and never forwarded
    R15 = 32'h20; RegWrite = 1'b1; A3 = 4'd15; WD3 = 32'hFFFFFFFF; A1 = 4'd15; #1;
    chk("pc_rd_during_wr", RD1, 32'h20);
    tick();
    RegWrite = 1'b0;
    chk("pc_rd_after_wr", RD1, 32'h20);
    for (int i = 0; i < 15; i++) begin
      A2 = 4'(i); #1;
      chk($sformatf("pc_wr_r%0d", i), RD2, mdl[i]);
    end

    // Async reset mid-write
    wr(4'd2, 32'hAAAA0000);
    A1 = 4'd2; #1;
    chk("pre_rst_r2", RD1, 32'hAAAA0000);
    RegWrite = 1'b1; A3 = 4'd2; WD3 = 32'h5555; #1;
    rst_n = 1'b0; #1;
    chk("async_rst_r2", RD1, 32'h0);
    chk("async_rst_nb_r2", RD1n, 32'h0);
    for (int i = 0; i < 15; i++) mdl[i] = '0;
    @(posedge clk); #1;
    chk("held_rst_r2", RD1, 32'h0);
    A1 = 4'd3; #1;
    chk("held_rst_r3", RD1, 32'h0);
    RegWrite = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Random sweep with frequent collisions
    for (int c = 0; c < 800; c++) begin
      RegWrite = 1'($urandom_range(0, 1));
      A3  = 4'($urandom_range(0, 15));
      A1  = ($urandom_range(0, 3) == 0) ? A3 : 4'($urandom_range(0, 15));
      A2  = ($urandom_range(0, 3) == 0) ? A1 : 4'($urandom_range(0, 15));
      WD3 = $urandom;
      R15 = $urandom;
      #1;
      chk("rnd_rd1", RD1, ref_rd(A1, 1'b1));
      chk("rnd_rd2", RD2, ref_rd(A2, 1'b1));
      chk("rnd_nb_rd1", RD1n, ref_rd(A1, 1'b0));
      chk("rnd_nb_rd2", RD2n, ref_rd(A2, 1'b0));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
